// File: rtl/ysyx_22050612_ifu_pq.sv
// Fetch unit with a DEPTH-entry in-order prefetch queue, redirect flush and stale-response drop.
// Optional misaligned-redirect fault entry: define YSYX_22050612_IFU_MISALIGN_EN.
module ysyx_22050612_ifu_pq #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);
  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam int unsigned      PTR_W    = IDX_W + 1;
  localparam int unsigned      CNT_W    = PTR_W + 4;
  localparam logic [PTR_W-1:0] FULL_OCC = PTR_W'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  pc_q [DEPTH];
  logic [XLEN-1:0]  pc_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      hold_inst_q, hold_inst_d;
  logic [XLEN-1:0]  hold_pc_q, hold_pc_d;
  logic             hold_fault_q, hold_fault_d;

  logic [IDX_W-1:0] head_idx, fill_idx, tail_idx;
  logic [PTR_W-1:0] occ, inflight;
  logic             dropping, req_fire, rsp_store, rsp_drop, rsp_counted, q_valid, q_pop;
  logic             fetch_en, fault_valid;
  logic [XLEN-1:0]  redir_pc, fault_pc;

  assign head_idx = head_q[IDX_W-1:0];
  assign fill_idx = fill_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign occ      = tail_q - head_q;
  assign inflight = tail_q - fill_q;
  assign dropping = drop_q != '0;

  assign imem_req_valid = fetch_en && (occ != FULL_OCC) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_store      = imem_rsp_valid && !dropping;
  assign rsp_drop       = imem_rsp_valid && dropping;
  assign rsp_counted    = imem_rsp_valid && (dropping || inflight != '0);
  assign q_valid        = filled_q[head_idx];
  assign q_pop          = q_valid && !fault_valid && inst_ready;

`ifdef YSYX_22050612_IFU_MISALIGN_EN
  typedef enum logic [1:0] {RUN, FAULT, HALT} state_e;
  state_e          state_q, state_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  assign fetch_en    = state_q == RUN;
  assign fault_valid = (state_q == FAULT) && !dropping;
  assign fault_pc    = fault_pc_q;
  assign redir_pc    = redirect_pc;

  always_comb begin
    state_d    = state_q;
    fault_pc_d = fault_pc_q;
    if (fault_valid && inst_ready) state_d = HALT;
    if (redirect_valid) begin
      state_d    = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
      fault_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fault_pc_q <= fault_pc_d;
    end
  end
`else
  logic unused_pc_lsb;

  assign fetch_en      = 1'b1;
  assign fault_valid   = 1'b0;
  assign fault_pc      = '0;
  assign redir_pc      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_lsb = ^redirect_pc[1:0];
`endif

  // When the queue is empty the outputs replay the last delivered instruction.
  always_comb begin
    inst_valid = 1'b0;
    inst       = hold_inst_q;
    inst_pc    = hold_pc_q;
    inst_fault = hold_fault_q;
    if (fault_valid) begin
      inst_valid = 1'b1;
      inst       = '0;
      inst_pc    = fault_pc;
      inst_fault = 1'b1;
    end else if (q_valid) begin
      inst_valid = 1'b1;
      inst       = data_q[head_idx];
      inst_pc    = pc_q[head_idx];
      inst_fault = 1'b0;
    end
  end

  // NOTE: every variable gets its default first, so no path can infer a latch.
  always_comb begin
    head_d       = head_q;
    fill_d       = fill_q;
    tail_d       = tail_q;
    drop_d       = drop_q;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    data_d       = data_q;
    filled_d     = filled_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    hold_fault_d = hold_fault_q;

    if (inst_valid && inst_ready) begin
      hold_inst_d  = inst;
      hold_pc_d    = inst_pc;
      hold_fault_d = inst_fault;
    end
    if (q_pop) begin
      filled_d[head_idx] = 1'b0;
      head_d             = head_q + 1'b1;
    end
    if (req_fire) begin
      pc_d[tail_idx]     = fetch_pc_q;
      filled_d[tail_idx] = 1'b0;
      tail_d             = tail_q + 1'b1;
      fetch_pc_d         = fetch_pc_q + XLEN'(4);
    end
    if (rsp_store) begin
      data_d[fill_idx]   = imem_rsp_data;
      filled_d[fill_idx] = 1'b1;
      fill_d             = fill_q + 1'b1;
    end else if (rsp_drop) begin
      drop_d = drop_q - 1'b1;
    end
    // Redirect wins: everything still in flight becomes a response to discard.
    if (redirect_valid) begin
      head_d     = tail_q;
      fill_d     = tail_q;
      tail_d     = tail_q;
      filled_d   = '0;
      fetch_pc_d = redir_pc;
      drop_d     = drop_q + CNT_W'(inflight) - CNT_W'(rsp_counted);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q       <= '0;
      fill_q       <= '0;
      tail_q       <= '0;
      drop_q       <= '0;
      fetch_pc_q   <= RESET_PC;
      filled_q     <= '0;
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
      hold_fault_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      fill_q       <= fill_d;
      tail_q       <= tail_d;
      drop_q       <= drop_d;
      fetch_pc_q   <= fetch_pc_d;
      filled_q     <= filled_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      hold_fault_q <= hold_fault_d;
    end
  end

  // NOTE: payload storage has no reset; filled_q gates every read of it.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_ysyx_22050612_ifu_pq.sv
// Directed bench for ysyx_22050612_ifu_pq: vector table for streaming/full behaviour plus
// hand-written redirect, misalignment and PC-wrap sequences against a queue-based memory model.
module tb_ysyx_22050612_ifu_pq;
  localparam logic [63:0] P     = 64'h8000_0000;
  localparam logic [63:0] W_PC  = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk, rst;
  logic        req_valid, req_ready, rsp_valid, redirect_valid, inst_valid, inst_ready, inst_fault;
  logic [63:0] req_addr, redirect_pc, inst_pc;
  logic [31:0] rsp_data, inst;

  logic        w_req_valid, w_inst_valid, w_inst_fault;
  logic [63:0] w_req_addr, w_inst_pc;
  logic [31:0] w_inst;
  logic        w_req_ready, w_rsp_valid, w_redirect_valid, w_inst_ready;
  logic [31:0] w_rsp_data;
  logic [63:0] w_redirect_pc;

  ysyx_22050612_ifu_pq #(.XLEN(64), .RESET_PC(P), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  ysyx_22050612_ifu_pq #(.XLEN(64), .RESET_PC(W_PC), .DEPTH(4)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst),
    .inst_pc(w_inst_pc), .inst_fault(w_inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] pend[$];
  logic        s_rv, s_iv, s_fault;
  logic [63:0] s_addr, s_pc, s_w_addr;
  logic [31:0] s_inst;

  typedef struct {
    logic        rr;
    logic        ir;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_iv;
    logic [63:0] exp_pc;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the negedge, sample 1 ns later, return at the next negedge.
  task automatic cycle(input logic rr, input logic ir, input logic rsp_en,
                       input logic rd, input logic [63:0] rpc);
    req_ready      = rr;
    inst_ready     = ir;
    redirect_valid = rd;
    redirect_pc    = rpc;
    if (rsp_en && pend.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_data  = data_of(pend.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
    #1;
    s_rv     = req_valid;
    s_addr   = req_addr;
    s_iv     = inst_valid;
    s_pc     = inst_pc;
    s_inst   = inst;
    s_fault  = inst_fault;
    s_w_addr = w_req_addr;
    if (req_valid && req_ready) pend.push_back(req_addr);
    @(negedge clk);
  endtask

  // Reset is asserted between edges so the outputs must clear asynchronously.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst            = 1'b0;
    req_ready      = 1'b0;
    inst_ready     = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pend.delete();
    #1;
    check("rst req_valid", 64'(req_valid), 64'd1);
    check("rst req_addr", req_addr, P);
    check("rst inst_valid", 64'(inst_valid), 64'd0);
    check("rst inst", 64'(inst), 64'd0);
    check("rst inst_pc", inst_pc, 64'd0);
    check("rst inst_fault", 64'(inst_fault), 64'd0);
    check("rst wrap addr", w_req_addr, W_PC);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_ready = 1'b0; inst_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = '0;
    w_redirect_valid = 1'b0; w_redirect_pc = '0; w_inst_ready = 1'b0;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, P,            1'b0, 64'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, P + 64'h4,    1'b0, 64'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, P + 64'h8,    1'b1, P};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, P + 64'hC,    1'b1, P + 64'h4};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, P + 64'h10,   1'b1, P + 64'h8};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, P + 64'h14,   1'b1, P + 64'hC};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, P + 64'h18,   1'b1, P + 64'hC};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 64'h0,        1'b1, P + 64'hC};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 64'h0,        1'b1, P + 64'hC};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 64'h0,        1'b1, P + 64'hC};
    tbl[10] = '{1'b1, 1'b0, 1'b1, P + 64'h1C,   1'b1, P + 64'h10};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 64'h0,        1'b1, P + 64'h10};

    // PC wrap on the second request of the top-of-memory instance.
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("wrap addr c0", s_w_addr, W_PC);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("wrap addr c1", s_w_addr, 64'h0);

    // Streaming, back-pressure and full-queue vectors with a 1-cycle memory.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].rr, tbl[i].ir, 1'b1, 1'b0, 64'h0);
      check($sformatf("tbl[%0d] req_valid", i), 64'(s_rv), 64'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) check($sformatf("tbl[%0d] req_addr", i), s_addr, tbl[i].exp_addr);
      check($sformatf("tbl[%0d] inst_valid", i), 64'(s_iv), 64'(tbl[i].exp_iv));
      if (tbl[i].exp_iv) begin
        check($sformatf("tbl[%0d] inst_pc", i), s_pc, tbl[i].exp_pc);
        check($sformatf("tbl[%0d] inst", i), 64'(s_inst), 64'(data_of(tbl[i].exp_pc)));
        check($sformatf("tbl[%0d] inst_fault", i), 64'(s_fault), 64'd0);
      end
    end

    // From empty with decode stalled: exactly DEPTH requests, then one more after one pop.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
      check($sformatf("full req_valid c%0d", i), 64'(s_rv), 64'd1);
      check($sformatf("full req_addr c%0d", i), s_addr, P + 64'(4 * i));
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    check("full req_valid c4", 64'(s_rv), 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("full pop-cycle req_valid", 64'(s_rv), 64'd0);
    check("full pop inst_pc", s_pc, P);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    check("full refill req_valid", 64'(s_rv), 64'd1);
    check("full refill req_addr", s_addr, P + 64'h10);
    check("full refill head pc", s_pc, P + 64'h4);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    check("full again req_valid", 64'(s_rv), 64'd0);

    // Three requests in flight, then redirect: three responses must be discarded.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, P + 64'h100);
    check("drop redirect-cycle req_valid", 64'(s_rv), 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("drop restart req_valid", 64'(s_rv), 64'd1);
    check("drop restart req_addr", s_addr, P + 64'h100);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
      check($sformatf("drop stale inst_valid %0d", i), 64'(s_iv), 64'd0);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("drop first inst_valid", 64'(s_iv), 64'd1);
    check("drop first inst_pc", s_pc, P + 64'h100);
    check("drop first inst", 64'(s_inst), 64'(data_of(P + 64'h100)));

    // Redirect in the same cycle as the handshake of P+4.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, P + 64'h200);
    check("hs redirect inst_valid", 64'(s_iv), 64'd1);
    check("hs redirect inst_pc", s_pc, P + 64'h4);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("hs restart req_addr", s_addr, P + 64'h200);
    check("hs empty inst_valid", 64'(s_iv), 64'd0);
    check("hs hold inst_pc", s_pc, P + 64'h4);
    check("hs hold inst", 64'(s_inst), 64'(data_of(P + 64'h4)));
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("hs wait inst_valid", 64'(s_iv), 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("hs next inst_valid", 64'(s_iv), 64'd1);
    check("hs next inst_pc", s_pc, P + 64'h200);

    // Misaligned redirect.
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, P + 64'h102);
    check("mis redirect-cycle req_valid", 64'(s_rv), 64'd0);
`ifdef YSYX_22050612_IFU_MISALIGN_EN
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    check("mis fault req_valid", 64'(s_rv), 64'd0);
    check("mis fault inst_valid", 64'(s_iv), 64'd1);
    check("mis fault inst_fault", 64'(s_fault), 64'd1);
    check("mis fault inst_pc", s_pc, P + 64'h102);
    check("mis fault inst", 64'(s_inst), 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("mis pop req_valid", 64'(s_rv), 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("mis halt inst_valid", 64'(s_iv), 64'd0);
    check("mis halt req_valid", 64'(s_rv), 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, P + 64'h200);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("mis resume req_valid", 64'(s_rv), 64'd1);
    check("mis resume req_addr", s_addr, P + 64'h200);
`else
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("mis aligned req_valid", 64'(s_rv), 64'd1);
    check("mis aligned req_addr", s_addr, P + 64'h100);
    check("mis aligned inst_valid", 64'(s_iv), 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    check("mis aligned inst_pc", s_pc, P + 64'h100);
    check("mis aligned inst_fault", 64'(s_fault), 64'd0);
    check("mis aligned inst_valid2", 64'(s_iv), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22050612_ifu_pq.md
# ysyx_22050612_ifu_pq

Parametrised fetch unit with prefetch queue for the ysyx_22050612 core; successor to the single-cycle IFU. It generates sequential fetch PCs and issues pipelined requests over a valid/ready instruction-memory port. Responses are buffered in a DEPTH-entry in-order queue and delivered to decode over a valid/ready handshake. A redirect port flushes the queue and discards stale in-flight responses.

## Interface
- XLEN, 64, PC/address width
- RESET_PC, 64'h8000_0000, first fetch address after reset
- DEPTH, 4, queue entries including in-flight slots; power of 2, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  response valid; always accepted, in request order
- imem_rsp_data  in  32  fetched instruction
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch PC
- inst_valid  out  1  head entry valid
- inst_ready  in  1  decode accepts head
- inst  out  32  head instruction
- inst_pc  out  XLEN  PC of head instruction
- inst_fault  out  1  head is a misaligned-fetch fault entry

## Operation
- Queue entry = {pc, data, filled}. Pointers head/fill/tail, log2(DEPTH)+1 bits; wrap modulo 2·DEPTH.
- Issue: imem_req_valid = state==RUN && (tail−head)<DEPTH && !redirect_valid; imem_req_addr = fetch_pc. On req fire: entry[tail].pc=fetch_pc, filled=0, tail++, fetch_pc += 4 (wraps mod 2^XLEN).
- Memory side tolerates withdrawal of imem_req_valid on a redirect cycle.
- Response: if drop_cnt>0, discard and drop_cnt−−; else entry[fill].data=imem_rsp_data, filled=1, fill++.
- Output: inst_valid = entry[head].filled; inst/inst_pc/inst_fault from head; pop on inst_valid&&inst_ready.
- Redirect (highest priority): head=fill=tail; drop_cnt_next = drop_cnt + (tail−fill) − (rsp accepted as non-drop or drop this cycle ? 1 : 0); fetch_pc=redirect_pc; no request issued that cycle. An inst handshake in the redirect cycle completes normally; all other entries are lost.
- States: RUN (normal), FAULT (one fault entry pending), HALT (no fetch, awaiting redirect). FAULT/HALT exist only with the macro.
- Reset values: fetch_pc=RESET_PC, pointers 0, drop_cnt 0, all filled 0, state RUN; imem_req_valid=1 (credit available), inst_valid=0, inst=0, inst_pc=0, inst_fault=0.

## Timing
- Request issued combinationally from registered fetch_pc; first request in the first cycle after rst deasserts.
- Response at cycle T -> inst_valid at T+1 (if at head).
- Redirect at T -> request with redirect_pc at T+1.
- Sustained throughput 1 inst/cycle with zero-wait memory and inst_ready=1.
- Full: (tail−head)==DEPTH -> imem_req_valid=0 until a pop; pop and issue in same cycle permitted only when not full at cycle start.
- Empty: inst_valid=0; outputs hold last value.
- Async reset mid-transaction: all state cleared immediately; pending memory responses after reset are the integrator's responsibility (memory reset together).

## Configuration
- YSYX_22050612_IFU_MISALIGN_EN defined: redirect_pc[1:0]≠0 -> state FAULT, queue flushed as normal, no requests; once drop_cnt==0 a single entry {pc=redirect_pc, data=32'h0, fault=1} is presented; after its pop -> HALT; next redirect -> RUN (or FAULT again).
- Undefined: redirect_pc[1:0] forced to 2'b00, inst_fault tied 0, no FAULT/HALT states.

## Test plan
- Reset, RESET_PC default, 1-cycle memory, inst_ready=1 -> requests 0x8000_0000, 0x8000_0004, 0x8000_0008; insts delivered in order one per cycle with matching inst_pc.
- DEPTH=4, inst_ready=0, memory ready -> exactly 4 requests then imem_req_valid=0; one pop -> one further request at 0x8000_0010.
- 3 requests in flight, redirect to 0x8000_0100 -> next 3 responses discarded; next delivered inst_pc=0x8000_0100.
- Redirect in same cycle as inst handshake of 0x8000_0004 -> that inst consumed once; next inst_pc = redirect_pc.
- Macro on, redirect 0x8000_0102 -> one entry inst_fault=1, inst_pc=0x8000_0102, no requests; redirect 0x8000_0200 -> fetch resumes there.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second request address 64'h0.
